// File: rtl/npc_pkg.sv
// Shared NPC core constants: data width, GPR file depths, ABI register indices.
`default_nettype none

package npc_pkg;

  localparam int XLEN       = 32;
  localparam int RV_AW      = 5;
  localparam int NREG_RV32E = 16;
  localparam int NREG_RV32I = 32;
  localparam int REG_A0     = 10;

  // True when a 5-bit register field names a physically present GPR.
  function automatic logic addr_in_range(input logic [RV_AW-1:0] addr, input int nreg);
    return (int'(addr) < nreg);
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// Per-GPR pending bits marking destinations of in-flight instructions; drives IDU busy lookup.
`default_nettype none

module regfile_scoreboard
  import npc_pkg::*;
#(
  parameter int NREG = NREG_RV32E,
  parameter int AW   = RV_AW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 issue_valid_i,
  input  logic [AW-1:0]        issue_rd_i,
  input  logic                 exu_write_i,
  input  logic [AW-1:0]        exu_rd_addr_i,
  input  logic                 lsu_write_i,
  input  logic [AW-1:0]        lsu_rd_addr_i,
  input  logic [AW-1:0]        rs1_addr_i,
  input  logic [AW-1:0]        rs2_addr_i,
  output logic [(1<<AW)-1:0]   pending_o,
  output logic                 rs1_busy_o,
  output logic                 rs2_busy_o
);

  localparam int NSLOT = 1 << AW;

  logic [NSLOT-1:0] pending_q;
  logic [NSLOT-1:0] pending_d;

  // Bits 0 and >= NREG are never written, so they hold their reset value of 0.
  always_comb begin
    pending_d = pending_q;
    for (int i = 1; i < NREG; i++) begin
      if ((exu_write_i && exu_rd_addr_i == AW'(i)) ||
          (lsu_write_i && lsu_rd_addr_i == AW'(i))) begin
        pending_d[i] = 1'b0;
      end
      // A new issue supersedes the retiring write to the same register.
      if (issue_valid_i && issue_rd_i == AW'(i)) begin
        pending_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending_o  = pending_q;
  assign rs1_busy_o = (rs1_addr_i != '0) && addr_in_range(rs1_addr_i, NREG) && pending_q[rs1_addr_i];
  assign rs2_busy_o = (rs2_addr_i != '0) && addr_in_range(rs2_addr_i, NREG) && pending_q[rs2_addr_i];

endmodule

`default_nettype wire

// File: rtl/regfile_sb.sv
// NPC GPR file: two registered read ports, EXU/LSU writeback with optional bypass,
// illegal-address pulse and an integrated RAW scoreboard.
`default_nettype none

module regfile_sb
  import npc_pkg::*;
#(
  parameter int XLEN   = npc_pkg::XLEN,
  parameter int NREG   = NREG_RV32E,
  parameter int AW     = RV_AW,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic            exu_write,
  input  logic [AW-1:0]   exu_rd_addr,
  input  logic [XLEN-1:0] exu_rd_data,
  input  logic            lsu_write,
  input  logic [AW-1:0]   lsu_rd_addr,
  input  logic [XLEN-1:0] lsu_rd_data,
  output logic            ill_addr,
  output logic [XLEN-1:0] a0_out
);

  localparam int NSLOT = 1 << AW;

  logic [XLEN-1:0] regs_q [NSLOT];
  logic [XLEN-1:0] regs_d [NSLOT];
  logic [XLEN-1:0] rs1_data_q, rs1_data_d;
  logic [XLEN-1:0] rs2_data_q, rs2_data_d;
  logic            ill_q, ill_d;
  logic [NSLOT-1:0] w_pending;

  // LSU is assigned last so it wins a same-address collision (older instruction).
  always_comb begin
    regs_d = regs_q;
    for (int i = 1; i < NREG; i++) begin
      if (exu_write && exu_rd_addr == AW'(i)) regs_d[i] = exu_rd_data;
      if (lsu_write && lsu_rd_addr == AW'(i)) regs_d[i] = lsu_rd_data;
    end
  end

  function automatic logic [XLEN-1:0] read_mux(input logic [AW-1:0] addr);
    logic [XLEN-1:0] val;
    val = '0;
    if (addr != '0 && addr_in_range(addr, NREG)) begin
      val = regs_q[addr];
      if (BYPASS != 0) begin
        if (exu_write && exu_rd_addr == addr) val = exu_rd_data;
        if (lsu_write && lsu_rd_addr == addr) val = lsu_rd_data;
      end
    end
    return val;
  endfunction

  always_comb begin
    rs1_data_d = read_mux(rs1_addr);
    rs2_data_d = read_mux(rs2_addr);
    ill_d = !addr_in_range(rs1_addr, NREG)
         || !addr_in_range(rs2_addr, NREG)
         || (issue_valid && !addr_in_range(issue_rd, NREG))
         || (exu_write   && !addr_in_range(exu_rd_addr, NREG))
         || (lsu_write   && !addr_in_range(lsu_rd_addr, NREG));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSLOT; i++) regs_q[i] <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      ill_q      <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      ill_q      <= ill_d;
    end
  end

  regfile_scoreboard #(
    .NREG (NREG),
    .AW   (AW)
  ) u_scoreboard (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_valid_i (issue_valid),
    .issue_rd_i    (issue_rd),
    .exu_write_i   (exu_write),
    .exu_rd_addr_i (exu_rd_addr),
    .lsu_write_i   (lsu_write),
    .lsu_rd_addr_i (lsu_rd_addr),
    .rs1_addr_i    (rs1_addr),
    .rs2_addr_i    (rs2_addr),
    .pending_o     (w_pending),
    .rs1_busy_o    (rs1_busy),
    .rs2_busy_o    (rs2_busy)
  );

  assign rs1_data = rs1_data_q;
  assign rs2_data = rs2_data_q;
  assign ill_addr = ill_q;

`ifndef SYNTHESIS
  assign a0_out = regs_q[REG_A0];
`else
  assign a0_out = '0;
`endif

  logic w_unused;
  assign w_unused = ^w_pending;

endmodule

`default_nettype wire

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench: RV32E with/without bypass and RV32I instances share stimulus.
`default_nettype none

module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1_addr, rs2_addr, issue_rd, exu_rd_addr, lsu_rd_addr;
  logic        issue_valid, exu_write, lsu_write;
  logic [31:0] exu_rd_data, lsu_rd_data;

  logic [31:0] d_rs1, d_rs2, d_a0, n_rs1, n_rs2, n_a0, w_rs1, w_rs2, w_a0;
  logic        d_b1, d_b2, d_ill, n_b1, n_b2, n_ill, w_b1, w_b2, w_ill;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(32), .NREG(16), .AW(5), .BYPASS(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(d_rs1), .rs2_data(d_rs2), .rs1_busy(d_b1), .rs2_busy(d_b2),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .exu_write(exu_write), .exu_rd_addr(exu_rd_addr), .exu_rd_data(exu_rd_data),
    .lsu_write(lsu_write), .lsu_rd_addr(lsu_rd_addr), .lsu_rd_data(lsu_rd_data),
    .ill_addr(d_ill), .a0_out(d_a0));

  regfile_sb #(.XLEN(32), .NREG(16), .AW(5), .BYPASS(0)) u_nb (
    .clk(clk), .rst_n(rst_n), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(n_rs1), .rs2_data(n_rs2), .rs1_busy(n_b1), .rs2_busy(n_b2),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .exu_write(exu_write), .exu_rd_addr(exu_rd_addr), .exu_rd_data(exu_rd_data),
    .lsu_write(lsu_write), .lsu_rd_addr(lsu_rd_addr), .lsu_rd_data(lsu_rd_data),
    .ill_addr(n_ill), .a0_out(n_a0));

  regfile_sb #(.XLEN(32), .NREG(32), .AW(5), .BYPASS(1)) u_d32 (
    .clk(clk), .rst_n(rst_n), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(w_rs1), .rs2_data(w_rs2), .rs1_busy(w_b1), .rs2_busy(w_b2),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .exu_write(exu_write), .exu_rd_addr(exu_rd_addr), .exu_rd_data(exu_rd_data),
    .lsu_write(lsu_write), .lsu_rd_addr(lsu_rd_addr), .lsu_rd_data(lsu_rd_data),
    .ill_addr(w_ill), .a0_out(w_a0));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_rd = '0;
    exu_write = 1'b0; exu_rd_addr = '0; exu_rd_data = '0;
    lsu_write = 1'b0; lsu_rd_addr = '0; lsu_rd_data = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rs1_addr = '0; rs2_addr = '0; idle();
    tick(); tick();
    total++; if (d_rs1 !== 32'h0 || d_rs2 !== 32'h0) begin bad++; $display("FAIL reset_rdata got %h/%h want 0/0", d_rs1, d_rs2); end
    total++; if (d_ill !== 1'b0 || d_b1 !== 1'b0 || d_b2 !== 1'b0) begin bad++; $display("FAIL reset_flags got ill=%b b1=%b b2=%b want 0", d_ill, d_b1, d_b2); end
    total++; if (d_a0 !== 32'h0) begin bad++; $display("FAIL reset_a0 got %h want 0", d_a0); end
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    exu_write = 1'b1; exu_rd_addr = 5'd5; exu_rd_data = 32'hDEADBEEF;
    tick();
    idle(); rs1_addr = 5'd5; rs2_addr = 5'd0;
    total++; if (d_rs1 !== 32'h0) begin bad++; $display("FAIL read_latency got %h want 0", d_rs1); end
    tick();
    total++; if (d_rs1 !== 32'hDEADBEEF) begin bad++; $display("FAIL read_x5 got %h want deadbeef", d_rs1); end
    total++; if (d_rs2 !== 32'h0) begin bad++; $display("FAIL read_x0 got %h want 0", d_rs2); end
    total++; if (n_rs1 !== 32'hDEADBEEF) begin bad++; $display("FAIL read_x5_nobyp got %h want deadbeef", n_rs1); end
  endtask

  task automatic test_dual_write();
    rs1_addr = 5'd7; rs2_addr = 5'd0;
    exu_write = 1'b1; exu_rd_addr = 5'd7; exu_rd_data = 32'h11;
    lsu_write = 1'b1; lsu_rd_addr = 5'd7; lsu_rd_data = 32'h22;
    tick();
    idle();
    total++; if (d_rs1 !== 32'h22) begin bad++; $display("FAIL bypass_lsu_wins got %h want 22", d_rs1); end
    total++; if (n_rs1 !== 32'h0) begin bad++; $display("FAIL nobypass_old got %h want 0", n_rs1); end
    tick();
    total++; if (d_rs1 !== 32'h22 || n_rs1 !== 32'h22) begin bad++; $display("FAIL stored_x7 got %h/%h want 22/22", d_rs1, n_rs1); end
  endtask

  task automatic test_scoreboard();
    rs1_addr = 5'd0;
    issue_valid = 1'b1; issue_rd = 5'd3;
    tick();
    idle(); rs1_addr = 5'd3; rs2_addr = 5'd4;
    #1;
    total++; if (d_b1 !== 1'b1 || d_b2 !== 1'b0) begin bad++; $display("FAIL busy_after_issue got b1=%b b2=%b want 1/0", d_b1, d_b2); end
    lsu_write = 1'b1; lsu_rd_addr = 5'd3; lsu_rd_data = 32'h33;
    #1;
    total++; if (d_b1 !== 1'b1) begin bad++; $display("FAIL busy_not_bypassed got %b want 1", d_b1); end
    tick();
    idle();
    #1;
    total++; if (d_b1 !== 1'b0) begin bad++; $display("FAIL busy_cleared got %b want 0", d_b1); end
    issue_valid = 1'b1; issue_rd = 5'd3;
    exu_write = 1'b1; exu_rd_addr = 5'd3; exu_rd_data = 32'h44;
    tick();
    idle();
    #1;
    total++; if (d_b1 !== 1'b1) begin bad++; $display("FAIL set_over_clear got %b want 1", d_b1); end
    lsu_write = 1'b1; lsu_rd_addr = 5'd3; lsu_rd_data = 32'h55;
    tick();
    idle(); rs2_addr = 5'd0;
  endtask

  task automatic test_out_of_range();
    rs1_addr = 5'd0;
    exu_write = 1'b1; exu_rd_addr = 5'd20; exu_rd_data = 32'h55;
    tick();
    idle();
    total++; if (d_ill !== 1'b1) begin bad++; $display("FAIL ill_write got %b want 1", d_ill); end
    total++; if (w_ill !== 1'b0) begin bad++; $display("FAIL ill_write_rv32i got %b want 0", w_ill); end
    tick();
    total++; if (d_ill !== 1'b0) begin bad++; $display("FAIL ill_pulse_end got %b want 0", d_ill); end
    rs1_addr = 5'd20;
    tick();
    rs1_addr = 5'd0;
    total++; if (d_rs1 !== 32'h0 || d_ill !== 1'b1) begin bad++; $display("FAIL read_x20 got %h ill=%b want 0 ill=1", d_rs1, d_ill); end
    total++; if (w_rs1 !== 32'h55 || w_ill !== 1'b0) begin bad++; $display("FAIL read_x20_rv32i got %h ill=%b want 55 ill=0", w_rs1, w_ill); end
    tick();
    total++; if (d_ill !== 1'b0) begin bad++; $display("FAIL ill_not_sticky got %b want 0", d_ill); end
    issue_valid = 1'b1; issue_rd = 5'd20;
    tick();
    idle(); rs1_addr = 5'd20;
    #1;
    total++; if (d_b1 !== 1'b0 || d_ill !== 1'b1) begin bad++; $display("FAIL issue_x20 got busy=%b ill=%b want 0/1", d_b1, d_ill); end
    total++; if (w_b1 !== 1'b1) begin bad++; $display("FAIL issue_x20_rv32i got busy=%b want 1", w_b1); end
    rs1_addr = 5'd0;
    tick();
  endtask

  task automatic test_x0();
    exu_write = 1'b1; exu_rd_addr = 5'd0; exu_rd_data = 32'hFFFFFFFF;
    issue_valid = 1'b1; issue_rd = 5'd0;
    rs1_addr = 5'd0; rs2_addr = 5'd0;
    tick();
    idle();
    #1;
    total++; if (d_b1 !== 1'b0 || d_b2 !== 1'b0) begin bad++; $display("FAIL x0_busy got %b/%b want 0/0", d_b1, d_b2); end
    total++; if (d_rs1 !== 32'h0) begin bad++; $display("FAIL x0_bypass got %h want 0", d_rs1); end
    tick();
    total++; if (d_rs1 !== 32'h0 || d_rs2 !== 32'h0) begin bad++; $display("FAIL x0_read got %h/%h want 0/0", d_rs1, d_rs2); end
  endtask

  task automatic test_async_reset();
    exu_write = 1'b1; exu_rd_addr = 5'd10; exu_rd_data = 32'h1234;
    tick();
    idle();
    total++; if (d_a0 !== 32'h1234) begin bad++; $display("FAIL a0_view got %h want 1234", d_a0); end
    issue_valid = 1'b1; issue_rd = 5'd10;
    tick();
    idle(); rs1_addr = 5'd10;
    #1;
    total++; if (d_b1 !== 1'b1) begin bad++; $display("FAIL load_pending got %b want 1", d_b1); end
    tick();
    total++; if (d_rs1 !== 32'h1234) begin bad++; $display("FAIL read_x10 got %h want 1234", d_rs1); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (d_rs1 !== 32'h0 || d_b1 !== 1'b0 || d_a0 !== 32'h0) begin bad++; $display("FAIL async_clear got %h busy=%b a0=%h want 0", d_rs1, d_b1, d_a0); end
    exu_write = 1'b1; exu_rd_addr = 5'd10; exu_rd_data = 32'hBEEF;
    issue_valid = 1'b1; issue_rd = 5'd10;
    tick();
    idle();
    #2 rst_n = 1'b1;
    #1;
    total++; if (d_b1 !== 1'b0 || d_a0 !== 32'h0) begin bad++; $display("FAIL post_reset got busy=%b a0=%h want 0/0", d_b1, d_a0); end
    tick();
    total++; if (d_rs1 !== 32'h0) begin bad++; $display("FAIL post_reset_x10 got %h want 0", d_rs1); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_dual_write();
    test_scoreboard();
    test_out_of_range();
    test_x0();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got no completion want finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised GPR file with integrated scoreboard for the NPC core. It replaces the fixed RV32E 16-entry file and supports both RV32E and RV32I depth through parameters. It has two synchronous read ports, an EXU and an LSU writeback port, and write-to-read bypass. A per-register pending bit lets IDU detect RAW hazards against in-flight loads and multi-cycle EXU results.

Parameters:
XLEN, 32, data width
NREG, 16, number of GPRs (16 = RV32E, 32 = RV32I); must be 16 or 32
AW, 5, register address width (ISA field width; fixed at 5 for RV)
BYPASS, 1, 1 = same-cycle writeback forwarded into read data; 0 = read returns pre-write value

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rs1_addr  in  AW  read port 1 address
rs2_addr  in  AW  read port 2 address
rs1_data  out  XLEN  registered read data 1
rs2_data  out  XLEN  registered read data 2
rs1_busy  out  1  combinational: rs1_addr pending
rs2_busy  out  1  combinational: rs2_addr pending
issue_valid  in  1  IDU issues an instruction writing issue_rd
issue_rd  in  AW  destination of issued instruction
exu_write  in  1  EXU writeback enable
exu_rd_addr  in  AW  EXU writeback address
exu_rd_data  in  XLEN  EXU writeback data
lsu_write  in  1  LSU writeback enable
lsu_rd_addr  in  AW  LSU writeback address
lsu_rd_data  in  XLEN  LSU writeback data
ill_addr  out  1  registered: some valid access in the previous cycle used an address >= NREG
a0_out  out  XLEN  debug view of x10 (non-SYNTHESIS only)

Behaviour:
- Reset is asynchronous on rst_n low. It clears all registers, rs1_data, rs2_data, every pending bit and ill_addr to 0.
- Clocking: one clock, clk; reset is asynchronous and active-low (rst_n).
- Read latency is 1 cycle: rs*_data at edge N+1 reflects rs*_addr sampled at edge N.
- Read of address 0 returns 0. Read of address >= NREG returns 0 and sets ill_addr next cycle.
- BYPASS=1: if a write to the same nonzero, in-range address happens in the same cycle as the read, the written value is returned. If both ports write that address, the LSU value is returned.
- BYPASS=0: a same-cycle write is not forwarded; the read returns the old value.
- Writes are ignored when the address is 0 or >= NREG; an out-of-range write sets ill_addr.
- If exu_write and lsu_write target the same address in the same cycle, LSU wins (it is the older instruction).
- Scoreboard, one pending bit per register (index 0 is never set). Evaluated per edge:
  - Clear pending[a] on exu_write or lsu_write to a.
  - Set pending[a] on issue_valid with issue_rd = a. Set has priority over clear on the same address, because the new issue supersedes the retiring write.
  - Issue to 0 or to an address >= NREG does not set pending; out-of-range also sets ill_addr.
- rs*_busy = pending[rs*_addr] for nonzero in-range addresses; otherwise 0.
  - This is purely combinational and is not bypassed by same-cycle writeback; IDU stalls one extra cycle in that case.
- ill_addr is a 1-cycle pulse per offending cycle, not sticky.
- For NREG=16, address bit 4 is checked; for NREG=32, all addresses are in range and ill_addr stays 0.
- Reset asserted mid-operation clears state immediately. Writes in the reset cycle are lost, and the scoreboard is empty on release.

Decomposition:
- Shared package npc_pkg holds XLEN, the NREG_RV32E=16 and NREG_RV32I=32 constants, and the ABI index constant REG_A0=10.
- One natural sub-module, regfile_scoreboard. It holds the pending bit vector plus set/clear priority logic and exposes pending and busy lookup. It keeps data storage and bypass in the top.

Test Plan:
- Reset, then write x5=0xDEADBEEF via EXU. Read rs1=5 next cycle -> rs1_data=0xDEADBEEF one cycle after address. rs2=0 -> 0.
- BYPASS=1: EXU writes x7=0x11 and LSU writes x7=0x22 in the same cycle, with rs1_addr=7 that cycle -> rs1_data=0x22 next cycle and stored x7=0x22. With BYPASS=0 the same stimulus -> rs1_data=old value (0).
- Issue rd=3 -> rs1_busy=1 for rs1_addr=3 the next cycle. LSU writeback x3 -> busy 0 the following cycle. Issue rd=3 concurrent with EXU writeback x3 -> busy stays 1.
- NREG=16: write x20=0x55 -> no register changes, ill_addr=1 for exactly one cycle. Read x20 -> rs1_data=0, ill_addr pulse. Issue rd=20 -> no busy. NREG=32: same write stores 0x55, ill_addr=0.
- Write x0=0xFFFFFFFF and issue rd=0 -> x0 reads 0, rs*_busy=0.
- Load pending on x10, then assert rst_n low mid-sequence -> all outputs 0 asynchronously. After release, x10 reads 0, busy 0, a0_out=0.
